ws2812_rx: RTL and testbench

- Receives a WS2812 single-wire NRZ stream and decodes it back into 24-bit GRB pixel words. It is the receive end of the stream our PWM bit encoder produces.
- Used as a loopback checker on the lamp board, and as the input stage for daisy-chain snooping.
- Measures the high time of each bit period to decide 0 or 1.
- Assembles bits MSB-first into 24-bit words and detects the latch/reset gap that ends a frame.

---
 rtl/ws2812_rx.sv | 163 ++++++++++++++++
 tb/tb_ws2812_rx.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ receiver: pulse-width bit decode into 24-bit GRB words
module ws2812_rx #(
    parameter int CNT_THRESH   = 28,
    parameter int CNT_MIN_HIGH = 8,
    parameter int CNT_MAX_HIGH = 60,
    parameter int CNT_RESET    = 3250,
    parameter int IDX_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic             frame_done,
    output logic             err_glitch,
    output logic             err_long,
    output logic             err_partial
);

    localparam logic [11:0] THRESH   = 12'(CNT_THRESH);
    localparam logic [11:0] MIN_HIGH = 12'(CNT_MIN_HIGH);
    localparam logic [11:0] MAX_HIGH = 12'(CNT_MAX_HIGH);
    localparam logic [11:0] GAP      = 12'(CNT_RESET);
    localparam logic [11:0] SAT      = 12'hFFF;

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t      state, state_nx;
    logic        s1, s2, s2_d;
    logic        rise, fall;
    logic [11:0] hi_cnt, lo_cnt;
    logic [4:0]  bit_cnt, bit_cnt_nx;
    logic [22:0] shift, shift_nx;
    logic        any_pix, any_pix_nx;
    logic        bit_val;
    logic        clr_index;
    logic        valid_nx, done_nx, glitch_nx, long_nx, partial_nx;

    assign rise    = s2 & ~s2_d;
    assign fall    = ~s2 & s2_d;
    assign bit_val = (hi_cnt >= THRESH);

    // Synchronizer, edge delay and the saturating width counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s2_d   <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s2_d <= s2;
            if (rise)
                hi_cnt <= 12'd1;
            else if (s2 && hi_cnt != SAT)
                hi_cnt <= hi_cnt + 12'd1;
            if (rise)
                lo_cnt <= '0;
            else if (!s2 && lo_cnt != SAT)
                lo_cnt <= lo_cnt + 12'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        any_pix_nx = any_pix;
        clr_index  = 1'b0;
        valid_nx   = 1'b0;
        done_nx    = 1'b0;
        glitch_nx  = 1'b0;
        long_nx    = 1'b0;
        partial_nx = 1'b0;
        if (!en) begin
            state_nx = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC: if (lo_cnt >= GAP) state_nx = ST_IDLE;
                ST_IDLE: if (rise) state_nx = ST_HIGH;
                ST_HIGH: begin
                    if (hi_cnt > MAX_HIGH) begin
                        long_nx  = 1'b1;
                        state_nx = ST_SYNC;
                    end else if (fall) begin
                        if (hi_cnt < MIN_HIGH) begin
                            glitch_nx = 1'b1;
                            state_nx  = ST_SYNC;
                        end else begin
                            if (bit_cnt == 5'd23) begin
                                valid_nx   = 1'b1;
                                any_pix_nx = 1'b1;
                                bit_cnt_nx = '0;
                                shift_nx   = '0;
                            end else begin
                                bit_cnt_nx = bit_cnt + 5'd1;
                                shift_nx   = {shift[21:0], bit_val};
                            end
                            state_nx = ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    // The gap check wins over a coincident rise, which is dropped.
                    if (lo_cnt >= GAP) begin
                        if (bit_cnt == 5'd0)
                            done_nx = any_pix;
                        else
                            partial_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (rise) begin
                        state_nx = ST_HIGH;
                    end
                end
                default: state_nx = ST_SYNC;
            endcase
        end
        if (state_nx == ST_SYNC || state_nx == ST_IDLE) begin
            bit_cnt_nx = '0;
            shift_nx   = '0;
            any_pix_nx = 1'b0;
            clr_index  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SYNC;
            bit_cnt     <= '0;
            shift       <= '0;
            any_pix     <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_index   <= '0;
            frame_done  <= 1'b0;
            err_glitch  <= 1'b0;
            err_long    <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            shift       <= shift_nx;
            any_pix     <= any_pix_nx;
            pix_valid   <= valid_nx;
            frame_done  <= done_nx;
            err_glitch  <= glitch_nx;
            err_long    <= long_nx;
            err_partial <= partial_nx;
            if (valid_nx)
                pix_data <= {shift, bit_val};
            // Index steps after the strobe so it names the pixel being presented.
            if (clr_index)
                pix_index <= '0;
            else if (pix_valid)
                pix_index <= pix_index + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx
module tb_ws2812_rx;

    localparam int CNT_THRESH   = 28;
    localparam int CNT_MIN_HIGH = 8;
    localparam int CNT_MAX_HIGH = 60;
    localparam int CNT_RESET    = 3250;
    localparam int IDX_W        = 10;
    localparam int GAP_LONG     = 3300;

    localparam int EV_PIX    = 0;
    localparam int EV_DONE   = 1;
    localparam int EV_GLITCH = 2;
    localparam int EV_LONG   = 3;
    localparam int EV_PART   = 4;

    localparam int M_SYNC  = 0;
    localparam int M_IDLE  = 1;
    localparam int M_FRAME = 2;

    logic             clk, rst, en, din;
    logic [23:0]      pix_data;
    logic             pix_valid;
    logic [IDX_W-1:0] pix_index;
    logic             frame_done, err_glitch, err_long, err_partial;

    ws2812_rx #(
        .CNT_THRESH  (CNT_THRESH),
        .CNT_MIN_HIGH(CNT_MIN_HIGH),
        .CNT_MAX_HIGH(CNT_MAX_HIGH),
        .CNT_RESET   (CNT_RESET),
        .IDX_W       (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .err_glitch (err_glitch),
        .err_long   (err_long),
        .err_partial(err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
    } ev_t;

    typedef struct {
        logic [23:0] word;
        int          h0, h1, lo0, lo1;
        logic [23:0] exp_data;
    } vec_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: works on whole pulse widths, not on clock cycles.
    int          m_mode;
    bit          m_skip;
    logic [23:0] m_acc;
    int          m_nbits, m_npix, m_idx;
    int          pend_lo;
    bit          model_on;

    always @(negedge clk) begin
        int nstr;
        nstr = int'(pix_valid) + int'(frame_done) + int'(err_glitch) + int'(err_long) + int'(err_partial);
        if (pix_valid)   obs_q.push_back('{EV_PIX, pix_data, int'(pix_index)});
        if (frame_done)  obs_q.push_back('{EV_DONE, 24'h0, 0});
        if (err_glitch)  obs_q.push_back('{EV_GLITCH, 24'h0, 0});
        if (err_long)    obs_q.push_back('{EV_LONG, 24'h0, 0});
        if (err_partial) obs_q.push_back('{EV_PART, 24'h0, 0});
        if (nstr > 0) begin
            checks++;
            if (nstr > 1) begin
                errors++;
                $display("FAIL strobe_exclusive act=%0d strobes exp=1", nstr);
            end
        end
    end

    function automatic void m_emit(input int kind, input logic [23:0] data, input int idx);
        if (model_on) exp_q.push_back('{kind, data, idx});
    endfunction

    function automatic void m_clear(input int mode);
        m_mode  = mode;
        m_skip  = 1'b0;
        m_acc   = '0;
        m_nbits = 0;
        m_npix  = 0;
        m_idx   = 0;
    endfunction

    function automatic void m_reset();
        m_clear(M_SYNC);
        pend_lo = 0;
    endfunction

    function automatic void model_low(input int len);
        if (m_mode != M_IDLE && len >= CNT_RESET) begin
            if (m_mode == M_FRAME) begin
                if (m_nbits > 0)     m_emit(EV_PART, 24'h0, 0);
                else if (m_npix > 0) m_emit(EV_DONE, 24'h0, 0);
            end
            m_clear(M_IDLE);
            m_skip = (len == CNT_RESET);
        end
    endfunction

    function automatic void model_high(input int w);
        if (m_mode == M_SYNC) return;
        if (m_skip) begin
            m_skip = 1'b0;
            return;
        end
        if (w > CNT_MAX_HIGH) begin
            m_emit(EV_LONG, 24'h0, 0);
            m_clear(M_SYNC);
        end else if (w < CNT_MIN_HIGH) begin
            m_emit(EV_GLITCH, 24'h0, 0);
            m_clear(M_SYNC);
        end else begin
            m_acc = {m_acc[22:0], (w >= CNT_THRESH) ? 1'b1 : 1'b0};
            m_nbits++;
            if (m_nbits == 24) begin
                m_emit(EV_PIX, m_acc, m_idx);
                m_idx   = (m_idx + 1) % (1 << IDX_W);
                m_npix++;
                m_nbits = 0;
            end
            m_mode = M_FRAME;
        end
    endfunction

    task automatic seg(input logic level, input int n);
        din = level;
        if (level) begin
            if (pend_lo > 0) model_low(pend_lo);
            pend_lo = 0;
            model_high(n);
        end else begin
            pend_lo += n;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        if (pend_lo > CNT_RESET) begin
            model_low(pend_lo);
            pend_lo = 0;
        end
    endtask

    task automatic send_bits(input logic [23:0] word, input int first, input int count,
                             input int h0, input int h1, input int lo0, input int lo1);
        for (int i = 0; i < count; i++) begin
            if (word[first-i]) begin
                seg(1'b1, h1);
                seg(1'b0, lo1);
            end else begin
                seg(1'b1, h0);
                seg(1'b0, lo0);
            end
        end
    endtask

    task automatic send_word(input logic [23:0] word);
        send_bits(word, 23, 24, 18, 38, 10, 10);
    endtask

    function automatic void expect_ev(input int kind, input logic [23:0] data, input int idx);
        exp_q.push_back('{kind, data, idx});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_pix_data"},    32'(pix_data), 32'h0);
        chk({name, "_pix_valid"},   32'(pix_valid), 32'h0);
        chk({name, "_pix_index"},   32'(pix_index), 32'h0);
        chk({name, "_frame_done"},  32'(frame_done), 32'h0);
        chk({name, "_err_glitch"},  32'(err_glitch), 32'h0);
        chk({name, "_err_long"},    32'(err_long), 32'h0);
        chk({name, "_err_partial"}, 32'(err_partial), 32'h0);
    endtask

    task automatic check_events(input string name);
        int n;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s event_count act=%0d exp=%0d", name, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].idx != exp_q[i].idx) begin
                errors++;
                $display("FAIL %s event%0d act kind=%0d data=%06h idx=%0d exp kind=%0d data=%06h idx=%0d",
                         name, i, obs_q[i].kind, obs_q[i].data, obs_q[i].idx,
                         exp_q[i].kind, exp_q[i].data, exp_q[i].idx);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string name);
        din = 1'b0;
        rst = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        check_zero(name);
        rst = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{24'hFF0055, 18, 38, 60, 40, 24'hFF0055};
        vecs[1] = '{24'hA5C33C, 27, 28, 10, 10, 24'hA5C33C};
        vecs[2] = '{24'h123456, 28, 60, 10, 10, 24'hFFFFFF};
        vecs[3] = '{24'hABCDEF,  8, 27, 10, 10, 24'h000000};

        model_on = 1'b0;
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b0;
        m_reset();
        @(negedge clk);
        do_reset("reset");

        // Gap after reset alone: no frame, no strobe.
        seg(1'b0, GAP_LONG);
        flush();
        check_events("lead_gap");

        for (int v = 0; v < 4; v++) begin
            send_bits(vecs[v].word, 23, 24, vecs[v].h0, vecs[v].h1, vecs[v].lo0, vecs[v].lo1);
            seg(1'b0, GAP_LONG);
            flush();
            expect_ev(EV_PIX, vecs[v].exp_data, 0);
            expect_ev(EV_DONE, 24'h0, 0);
            check_events($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_hold", v), 32'(pix_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_index", v), 32'(pix_index), 32'h0);
        end

        // 3249 low cycles keep the frame; exactly 3250 ends it and the coincident rise is dropped.
        send_bits(24'h3C5A96, 23, 8, 18, 38, 10, 10);
        seg(1'b0, CNT_RESET - 1 - 10);
        send_bits(24'h3C5A96, 15, 16, 18, 38, 10, 10);
        seg(1'b0, CNT_RESET - 10);
        seg(1'b1, 38);
        seg(1'b0, 10);
        send_word(24'hC0FFEE);
        seg(1'b0, GAP_LONG);
        flush();
        expect_ev(EV_PIX, 24'h3C5A96, 0);
        expect_ev(EV_DONE, 24'h0, 0);
        expect_ev(EV_PIX, 24'hC0FFEE, 0);
        expect_ev(EV_DONE, 24'h0, 0);
        check_events("gap_boundary");

        seg(1'b1, 5);
        seg(1'b0, 10);
        send_bits(24'hFFFFFF, 23, 8, 18, 38, 10, 10);
        seg(1'b0, GAP_LONG);
        seg(1'b1, 61);
        seg(1'b0, 10);
        send_bits(24'hFFFFFF, 23, 8, 18, 38, 10, 10);
        seg(1'b0, GAP_LONG);
        send_word(24'h5AA5F0);
        seg(1'b0, GAP_LONG);
        flush();
        expect_ev(EV_GLITCH, 24'h0, 0);
        expect_ev(EV_LONG, 24'h0, 0);
        expect_ev(EV_PIX, 24'h5AA5F0, 0);
        expect_ev(EV_DONE, 24'h0, 0);
        check_events("errors");

        send_word(24'h112233);
        send_word(24'h445566);
        send_bits(24'h778899, 23, 10, 18, 38, 10, 10);
        seg(1'b0, GAP_LONG);
        flush();
        expect_ev(EV_PIX, 24'h112233, 0);
        expect_ev(EV_PIX, 24'h445566, 1);
        expect_ev(EV_PART, 24'h0, 0);
        check_events("partial");

        // Stream already running when reset releases: ignored until a full gap.
        do_reset("reset2");
        send_bits(24'hF0F0F0, 23, 10, 18, 38, 10, 10);
        seg(1'b0, GAP_LONG);
        send_word(24'h0BADF0);
        seg(1'b0, GAP_LONG);
        flush();
        expect_ev(EV_PIX, 24'h0BADF0, 0);
        expect_ev(EV_DONE, 24'h0, 0);
        check_events("startup");

        // Asynchronous reset in the middle of a high pulse.
        send_bits(24'hDEADBE, 23, 12, 18, 38, 10, 10);
        din = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        din = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seg(1'b0, GAP_LONG);
        flush();
        check_events("rst_mid");

        // Enable dropped mid-word: partial word vanishes without a strobe.
        send_bits(24'h13579B, 23, 12, 18, 38, 10, 10);
        en = 1'b0;
        m_clear(M_SYNC);
        seg(1'b0, 5);
        en = 1'b1;
        send_bits(24'h13579B, 11, 12, 18, 38, 10, 10);
        seg(1'b0, GAP_LONG);
        send_word(24'h2468AC);
        seg(1'b0, GAP_LONG);
        flush();
        expect_ev(EV_PIX, 24'h2468AC, 0);
        expect_ev(EV_DONE, 24'h0, 0);
        check_events("enable");

        model_on = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int nb;
            nb = 24 * int'($urandom_range(1, 2));
            if ($urandom_range(0, 2) == 0) nb += int'($urandom_range(1, 23));
            for (int i = 0; i < nb; i++) begin
                int w;
                if ($urandom_range(0, 19) == 0)
                    w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(61, 70));
                else
                    w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(8, 27)) : int'($urandom_range(28, 60));
                seg(1'b1, w);
                seg(1'b0, int'($urandom_range(1, 20)));
            end
            if ($urandom_range(0, 1) == 0)
                seg(1'b0, CNT_RESET - pend_lo);
            else
                seg(1'b0, GAP_LONG);
        end
        seg(1'b0, GAP_LONG);
        flush();
        check_events("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
